// File: rtl/riscv_pkg.sv
// Shared constants and types for the operand fetch slice.
package riscv_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    localparam logic [REG_ADDR_WIDTH-1:0] X0_ADDR = '0;

    typedef enum logic [1:0] {
        StIdle,
        StReadRs2,
        StValid
    } fetch_state_t;

endpackage

// File: rtl/operand_bypass.sv
// Operand capture mux: x0 reads as zero, a same-cycle writeback wins over the
// register file's combinational read data.
module operand_bypass
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] address,
    input  logic [XLEN-1:0]           rf_read_value,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_address,
    input  logic [XLEN-1:0]           wb_value,
    output logic [XLEN-1:0]           value
);

    always_comb begin
        value = rf_read_value;
        if (address == X0_ADDR) begin
            value = '0;
        end else if (wb_valid && (wb_address == address)) begin
            value = wb_value;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Reads rs1 then (optionally) rs2 through the single register file read port and
// holds both operands for execute until handoff.
module operand_fetch
    import riscv_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_uses_rs2,
    output logic [REG_ADDR_WIDTH-1:0] rf_read_address,
    input  logic [XLEN-1:0]           rf_read_value,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_address,
    input  logic [XLEN-1:0]           wb_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_rs1_value,
    output logic [XLEN-1:0]           out_rs2_value,
    output logic [REG_ADDR_WIDTH-1:0] out_rd
);

    fetch_state_t state_q, state_d;

    logic [REG_ADDR_WIDTH-1:0] rs2_idx_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [XLEN-1:0]           rs1_val_q;
    logic [XLEN-1:0]           rs2_val_q;
    logic [XLEN-1:0]           capture_value;

    // One bypass on the read port serves both capture cycles.
    operand_bypass u_bypass (
        .address       (rf_read_address),
        .rf_read_value (rf_read_value),
        .wb_valid      (wb_valid),
        .wb_address    (wb_address),
        .wb_value      (wb_value),
        .value         (capture_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = in_uses_rs2 ? StReadRs2 : StValid;
                end
            end
            StReadRs2: state_d = StValid;
            StValid: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        rf_read_address = X0_ADDR;
        unique case (state_q)
            StIdle: begin
                in_ready        = 1'b1;
                rf_read_address = in_rs1;
            end
            StReadRs2: rf_read_address = rs2_idx_q;
            StValid:   out_valid = 1'b1;
            default: begin
                in_ready        = 1'b0;
                out_valid       = 1'b0;
                rf_read_address = X0_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs2_idx_q <= '0;
            rd_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        rs2_idx_q <= in_rs2;
                        rd_q      <= in_rd;
                        rs1_val_q <= capture_value;
                        if (!in_uses_rs2) begin
                            rs2_val_q <= '0;
                        end
                    end
                end
                StReadRs2: rs2_val_q <= capture_value;
                default: ;
            endcase
        end
    end

    assign out_rs1_value = rs1_val_q;
    assign out_rs2_value = rs2_val_q;
    assign out_rd        = rd_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Sequences register-operand reads for one instruction at a time through the register file's single read port, then presents both source values to the execute stage. Sits between decode and execute; it is the sole driver of the register file read address. It forwards a same-cycle writeback so a value written in the read cycle is never returned stale.

## Interface
- XLEN, 32, data width of register values
- REG_ADDR_WIDTH, 5, register index width
- clk  input  1  clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  block accepts an instruction this cycle
- in_rs1, in_rs2, in_rd  input  REG_ADDR_WIDTH each  source and destination indices
- in_uses_rs2  input  1  instruction reads rs2
- rf_read_address  output  REG_ADDR_WIDTH  register file read index
- rf_read_value  input  XLEN  register file read data, combinational from rf_read_address
- wb_valid  input  1  register file write occurs at the end of this cycle
- wb_address  input  REG_ADDR_WIDTH  write index, same signal as the register file's
- wb_value  input  XLEN  write data, same signal as the register file's
- out_valid  output  1  operands valid for execute
- out_ready  input  1  execute accepts operands
- out_rs1_value, out_rs2_value  output  XLEN each  operand values
- out_rd  output  REG_ADDR_WIDTH  destination index passed through

## Operation
- States: IDLE, READ_RS2, VALID.
- IDLE: in_ready=1; rf_read_address=in_rs1. On in_valid: capture in_rs2, in_rd, in_uses_rs2; capture rs1 operand; go to READ_RS2 if in_uses_rs2, else VALID with rs2 operand 0.
- READ_RS2: in_ready=0; rf_read_address=captured rs2; capture rs2 operand; go to VALID.
- VALID: in_ready=0; out_valid=1; rf_read_address=0; outputs held stable until out_ready=1; on out_ready go to IDLE.
- Operand capture rule, for read index a: if a==0 -> 0; else if wb_valid and wb_address==a -> wb_value; else rf_read_value.
- Captured operands are snapshots; later writebacks do not update them. RAW ordering across instructions is decode's responsibility.
- Writes to x0 are never forwarded; x0 always yields 0 even if rf_read_value is nonzero.

## Timing
- Reset (async, any state): state=IDLE, out_valid=0, out_rs1_value=0, out_rs2_value=0, out_rd=0, in_ready=1 immediately. An instruction in flight is discarded.
- Accept in cycle N (in_valid & in_ready). With rs2: READ_RS2 in N+1, out_valid from N+2. Without rs2: out_valid from N+1.
- Handoff in cycle M (out_valid & out_ready) -> in_ready=1 in M+1. There is no accept in the handoff cycle. Peak throughput: one instruction per 3 cycles, or per 2 without rs2.
- out_valid, once high, stays high with unchanged data until the handoff. in_valid while in_ready=0 is ignored; decode holds it.
- wb_* are sampled only in the capture cycle. A write in any other cycle reaches the register file normally and is seen by later reads.

## Structure
- Shared package riscv_pkg: XLEN, REG_ADDR_WIDTH, the fetch-state enum (IDLE/READ_RS2/VALID) and the x0 index constant.
- One sub-module, operand_bypass: a combinational capture-rule mux (address, rf_read_value, wb_valid, wb_address, wb_value -> value). It is instanced once on rf_read_address, which makes it shared by both capture cycles.

## Test plan
- Reset, then rs1=2, rs2=3, uses_rs2=1 with regs 2=0x11, 3=0x22 preloaded -> out_valid in the 3rd cycle after accept; out_rs1_value=0x11, out_rs2_value=0x22, out_rd as given.
- rs1=0, rs2=0, with rf_read_value forced to 0xFFFFFFFF and wb_valid to x0 with value 5 -> both operands 0.
- In the accept cycle, wb_valid with address 4 and value 0xABCD, and rs1=4 (reg 4 old value 1) -> out_rs1_value=0xABCD. The same test in the READ_RS2 cycle with rs2=4 -> out_rs2_value=0xABCD.
- uses_rs2=0, rs1=7=0x77 -> out_valid in the 2nd cycle after accept, out_rs2_value=0. Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0. Then out_ready=1 -> in_ready=1 in the next cycle.
- Assert reset asynchronously while in READ_RS2 -> out_valid=0 and in_ready=1 before the next edge. A new instruction after release completes with correct values.
